// File: rtl/ppm_pkg.sv
// ppm_pkg: shared FSM type, CRC constants and field indices for the PPM byte assembler
package ppm_pkg;

    typedef enum logic [1:0] {IDLE, ASSEMBLE, DRAIN} ppm_state_t;

    localparam logic [15:0] CRC_POLY    = 16'h8408;
    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC_RESIDUE = 16'hF0B8;

    localparam int DIBIT_MSB = 1;
    localparam int DIBIT_LSB = 0;
    localparam int EOF_BIT   = 2;

    // LSB-first byte update of the reflected CRC-16
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++)
            c = (c >> 1) ^ ((c[0] ^ data[i]) ? CRC_POLY : 16'h0000);
        return c;
    endfunction

endpackage

// File: rtl/ppm_byte_assembler_if.sv
// ppm_byte_assembler_if: dibit strobe input, byte stream output and frame status
interface ppm_byte_assembler_if;
    logic       state;
    logic [2:0] data_3bits_in;
    logic       finish2bits_in;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       frame_done;
    logic       frame_err;
    logic       overflow;
    logic [6:0] byte_cnt;
    logic       crc_ok;

    modport slave (
        input  state, data_3bits_in, finish2bits_in, byte_ready,
        output byte_out, byte_valid, frame_done, frame_err, overflow, byte_cnt, crc_ok
    );

    modport master (
        output state, data_3bits_in, finish2bits_in, byte_ready,
        input  byte_out, byte_valid, frame_done, frame_err, overflow, byte_cnt, crc_ok
    );
endinterface

// File: rtl/ppm_crc16.sv
// ppm_crc16: byte-wide CRC-16 register with synchronous init and update enable
module ppm_crc16 import ppm_pkg::*; (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);
    logic [15:0] r_crc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_crc <= CRC_INIT;
        else if (i_init)
            r_crc <= CRC_INIT;
        else if (i_en)
            r_crc <= crc16_byte(r_crc, i_data);
    end

    assign o_crc = r_crc;
endmodule

// File: rtl/ppm_byte_assembler.sv
// ppm_byte_assembler: packs PPM dibits LSB-first into bytes behind a small FIFO.
// Define PPM_CRC16_EN to check the CRC-16 residue at end of frame.
module ppm_byte_assembler import ppm_pkg::*; #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BYTES  = 64
) (
    input logic                 clk16,
    input logic                 rst_n,
    ppm_byte_assembler_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] MAX_B = 8'(MAX_BYTES);

    ppm_state_t r_state, w_state_nx;

    logic [7:0]    r_shift;
    logic [1:0]    r_k;
    logic [6:0]    r_byte_cnt;
    logic          r_overflow;
    logic          r_len_err;
    logic          r_frame_err;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;

    logic          w_start;
    logic          w_eof;
    logic          w_dibit;
    logic          w_frame_done;
    logic [7:0]    w_byte;
    logic          w_byte_done;
    logic          w_keep;
    logic          w_pop;
    logic          w_push;
    logic [AW-1:0] w_wr_ptr;

    always_ff @(posedge clk16) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx   = r_state;
        w_start      = 1'b0;
        w_eof        = 1'b0;
        w_dibit      = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.state) begin
                    w_state_nx = ASSEMBLE;
                    w_start    = 1'b1;
                end
            end
            ASSEMBLE: begin
                // a falling state aborts even if a strobe lands on the same edge
                if (!bus.state)
                    w_state_nx = IDLE;
                else if (bus.finish2bits_in && bus.data_3bits_in[EOF_BIT]) begin
                    w_state_nx = DRAIN;
                    w_eof      = 1'b1;
                end else
                    w_dibit = bus.finish2bits_in;
            end
            DRAIN: begin
                w_frame_done = 1'b1;
                w_state_nx   = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_byte = r_shift;
        w_byte[{r_k, 1'b0} +: 2] = bus.data_3bits_in[DIBIT_MSB:DIBIT_LSB];
    end

    assign w_byte_done = w_dibit && (r_k == 2'd3);
    assign w_keep      = w_byte_done && ({1'b0, r_byte_cnt} < MAX_B);
    assign w_pop       = (r_cnt != '0) && bus.byte_ready;
    // depth is a power of two, so the count MSB alone means full; a same-cycle pop frees the slot
    assign w_push      = w_keep && (!r_cnt[AW] || w_pop);
    assign w_wr_ptr    = r_rd_ptr + r_cnt[AW-1:0];

    always_ff @(posedge clk16) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_k         <= '0;
            r_byte_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_len_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
        end else begin
            if (w_start) begin
                r_shift     <= '0;
                r_k         <= '0;
                r_byte_cnt  <= '0;
                r_overflow  <= 1'b0;
                r_len_err   <= 1'b0;
                r_frame_err <= 1'b0;
            end
            if (w_dibit) begin
                r_shift <= w_byte;
                r_k     <= r_k + 2'd1;
            end
            if (w_byte_done) begin
                r_byte_cnt <= r_byte_cnt + 7'(r_byte_cnt != 7'd127);
                if (!w_keep)
                    r_len_err <= 1'b1;
                else if (!w_push)
                    r_overflow <= 1'b1;
            end
            if (w_eof)
                r_frame_err <= (r_k != 2'd0) | r_len_err;
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_cnt    <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk16) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_push)
            r_mem[w_wr_ptr] <= w_byte;
    end

    assign bus.byte_valid = (r_cnt != '0);
    assign bus.byte_out   = bus.byte_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign bus.frame_done = w_frame_done;
    assign bus.frame_err  = r_frame_err;
    assign bus.overflow   = r_overflow;
    assign bus.byte_cnt   = r_byte_cnt;

`ifdef PPM_CRC16_EN
    logic [15:0] w_crc;
    logic        r_crc_ok;

    // every assembled byte feeds the CRC, even when the FIFO drops it
    ppm_crc16 u_crc (
        .i_clk   (clk16),
        .i_rst_n (rst_n),
        .i_init  (w_start),
        .i_en    (w_byte_done),
        .i_data  (w_byte),
        .o_crc   (w_crc)
    );

    always_ff @(posedge clk16) begin
        if (!rst_n)
            r_crc_ok <= 1'b0;
        else if (w_start)
            r_crc_ok <= 1'b0;
        else if (w_eof)
            r_crc_ok <= (w_crc == CRC_RESIDUE);
    end

    assign bus.crc_ok = r_crc_ok;
`else
    assign bus.crc_ok = w_frame_done;
`endif
endmodule

// File: doc/ppm_byte_assembler.md
# ppm_byte_assembler

Downstream stage of the 1-of-4 PPM receive path. Consumes the per-symbol dibit strobes from `Data_gen2bits` and packs four dibits, LSB-first, into bytes. Bytes are buffered in a small FIFO with a valid/ready handshake toward the frame/protocol layer. The block also reports frame completion, framing errors and overflow.

## Interface
- `FIFO_DEPTH`, default 4: output FIFO entries; must be a power of two and ≥2.
- `MAX_BYTES`, default 64: maximum bytes per frame before a length error is raised.

Ports:
- `clk16` in 1: 16× bit-rate clock; the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `state` in 1: receive-active level from the frame controller; low means idle or abort.
- `data_3bits_in` in 3: `[1:0]` = decoded dibit, `[2]` = end-of-frame marker.
- `finish2bits_in` in 1: single-cycle strobe; `data_3bits_in` is valid when this is high.
- `byte_out` out 8: FIFO head byte.
- `byte_valid` out 1: FIFO not empty.
- `byte_ready` in 1: consumer accepts `byte_out` when `byte_valid & byte_ready`.
- `frame_done` out 1: one-cycle pulse at the end of a frame.
- `frame_err` out 1: qualifies `frame_done`; set for a partial byte or a length error.
- `overflow` out 1: sticky; cleared at the start of the next frame.
- `byte_cnt` out 7: number of bytes assembled in the current or last frame.
- `crc_ok` out 1: qualifies `frame_done` (see Configuration).

## Operation
- **States.** `IDLE`, `ASSEMBLE`, `DRAIN`.
- **IDLE → ASSEMBLE** when `state` = 1. On entry:
  - clear the shift register and the dibit counter (2 bits);
  - clear `byte_cnt` and `overflow`;
  - load the CRC register with 0xFFFF.
- **Dibit strobe in ASSEMBLE** (`finish2bits_in` = 1 and `[2]` = 0):
  - Place `dibit` at bits `[2k+1:2k]`, where k is the dibit counter; then increment k.
  - When k = 3, the completed byte is pushed to the FIFO at that same edge, `byte_cnt` increments, and k wraps to 0.
- **Full FIFO at push:** the byte is dropped, `overflow` is set, and `byte_cnt` still increments.
- **Length limit:** when `byte_cnt` reaches `MAX_BYTES`, further bytes are discarded and a length error is latched.
- **EOF strobe in ASSEMBLE** (`finish2bits_in` = 1 and `[2]` = 1):
  - go to `DRAIN`;
  - `frame_err` = (k ≠ 0) | length error.
- **DRAIN:** `frame_done` pulses for exactly one cycle, then the FSM returns to `IDLE`.
- **`state` falling in ASSEMBLE:**
  - abort: the partial byte is discarded and the FSM goes to `IDLE`;
  - no `frame_done`;
  - bytes already in the FIFO remain.
- **Strobes in IDLE** are ignored.
- **Simultaneous push and pop with the FIFO full:** the pop takes effect first, so the push succeeds and there is no overflow.
- **`byte_cnt`** saturates at 127.

## Timing
- Reset values, with `rst_n` sampled low at a clock edge:
  - `byte_valid` = 0, `byte_out` = 0x00;
  - `frame_done` = 0, `frame_err` = 0, `overflow` = 0, `byte_cnt` = 0, `crc_ok` = 0;
  - FSM in `IDLE`, FIFO empty.
- Push latency: `byte_valid` rises 1 cycle after the 4th-dibit strobe when the FIFO was empty.
- `frame_done` is high in the cycle after the EOF strobe is sampled. `frame_err`, `crc_ok` and `byte_cnt` are stable in that cycle and hold until the next frame starts.
- `byte_out` is stable while `byte_valid` = 1 and `byte_ready` = 0.
- Reset asserted mid-frame: everything returns to reset values at that edge, including FIFO contents.
- Strobes are at least 8 cycles apart. The block still accepts back-to-back strobes.

## Configuration
- `PPM_CRC16_EN` defined:
  - CRC-16 uses reflected polynomial 0x8408 with init 0xFFFF.
  - Each assembled byte updates the CRC in the same cycle it is pushed, whether or not the FIFO accepts it.
  - At EOF, `crc_ok` = (CRC register == 0xF0B8), the residue over data plus the transmitted CRC.
- `PPM_CRC16_EN` undefined:
  - no CRC logic;
  - `crc_ok` is driven 1 in the cycle `frame_done` is high and 0 otherwise (0 at reset).

## Structure
- Shared package `ppm_pkg`:
  - FSM state enum (`IDLE`, `ASSEMBLE`, `DRAIN`);
  - `CRC_POLY` = 16'h8408, `CRC_INIT` = 16'hFFFF, `CRC_RESIDUE` = 16'hF0B8;
  - dibit/EOF bit indices.
- Sub-module `ppm_crc16`: byte-wide combinational CRC update plus register, with `init` and `en` inputs. Instantiated only under `PPM_CRC16_EN`.
- The FIFO is inline, using pointer plus count.

## Test plan
1. Dibits 01, 01, 10, 10 then EOF, with `byte_ready` = 1. Required:
   - `byte_out` = 0xA5 with `byte_valid` for 1 cycle;
   - `frame_done` with `frame_err` = 0 and `byte_cnt` = 1.
2. Frame 0x26 0x01 0x00 0xF6 0x0A with CRC enabled. Required:
   - 5 bytes delivered in order;
   - `crc_ok` = 1 at `frame_done`.
   - Corrupting 0x0A to 0x0B gives `crc_ok` = 0.
3. Six bytes with `byte_ready` = 0 and `FIFO_DEPTH` = 4. Required:
   - `overflow` = 1 and `byte_cnt` = 6;
   - draining yields the first 4 bytes only.
4. Seven dibits then EOF. Required:
   - one byte delivered;
   - `frame_done` with `frame_err` = 1.
5. `state` dropped after 2 dibits, then a new frame 0x3C. Required:
   - no `frame_done` for the aborted frame;
   - the next frame delivers 0x3C with `frame_err` = 0.
6. Reset asserted mid-byte with 2 bytes queued. Required:
   - next cycle `byte_valid` = 0 and `byte_cnt` = 0;
   - all outputs at their reset values.
